// File: rtl/seg_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_pkg
// Description : Shared constants and types for the seven-segment scan driver.
//               Holds digit-code constants, the active-low segment patterns
//               ({g,f,e,d,c,b,a}) and the scan FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_scan_pkg;

    // Special digit codes understood by the decoder
    localparam logic [10:0] CODE_BLANK = 11'd10;
    localparam logic [10:0] CODE_DASH  = 11'd11;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    typedef enum logic [0:0] {
        ST_GUARD = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decode
// Description : Combinational 11-bit digit code to active-low 7-segment
//               pattern. 0-9 decimal digits, 11 dash, 10 and 12-2047 blank.
// Ports       : code - digit code
//               seg  - segments {g,f,e,d,c,b,a}, active-low
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
    import seg_scan_pkg::*;
(
    input  logic [10:0] code,
    output logic [6:0]  seg
);

    always_comb begin
        seg = SEG_OFF;
        case (code)
            11'd0:      seg = SEG_DIGIT[0];
            11'd1:      seg = SEG_DIGIT[1];
            11'd2:      seg = SEG_DIGIT[2];
            11'd3:      seg = SEG_DIGIT[3];
            11'd4:      seg = SEG_DIGIT[4];
            11'd5:      seg = SEG_DIGIT[5];
            11'd6:      seg = SEG_DIGIT[6];
            11'd7:      seg = SEG_DIGIT[7];
            11'd8:      seg = SEG_DIGIT[8];
            11'd9:      seg = SEG_DIGIT[9];
            CODE_BLANK: seg = SEG_OFF;
            CODE_DASH:  seg = SEG_DASH;
            default:    seg = SEG_OFF;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver
// Description : Time-multiplexed 8-digit seven-segment scan driver. Requests
//               a digit code via `light`, samples `num` at the end of an
//               anode-off guard interval, decodes it and lights one
//               active-low anode per scan slot.
// Config      : SEG_SCAN_BLINK_EN - when defined, builds the blink divider
//               and blanks digits selected by `blink_mask` on alternate
//               blink halves. When undefined `blink_mask` is ignored.
// Ports       : clk, rst_n    - clock, asynchronous active-low reset
//               light  [2:0]  - digit position requested (0 = leftmost)
//               num    [10:0] - digit code for `light` (combinational source)
//               blink_mask[7:0], dp_mask[7:0] - per-digit blink / dp enables
//               an [7:0], seg [6:0], dp - active-low display pins
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int SCAN_HZ   = 1000,
    parameter int GUARD_CYC = 4,     // 1 <= GUARD_CYC <= P-2
    parameter int BLINK_HZ  = 2
)(
    input  logic        clk,
    input  logic        rst_n,
    output logic [2:0]  light,
    input  logic [10:0] num,
    input  logic [7:0]  blink_mask,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int C_PERIOD = CLK_HZ / SCAN_HZ;
    localparam int C_PRE_W  = (C_PERIOD > 1) ? $clog2(C_PERIOD) : 1;
    localparam int C_GRD_W  = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam logic [C_PRE_W-1:0] C_PRE_LAST = C_PRE_W'(C_PERIOD - 1);
    localparam logic [C_GRD_W-1:0] C_GRD_LAST = C_GRD_W'(GUARD_CYC - 1);

    scan_state_t          r_state;
    scan_state_t          w_state_next;
    logic [C_PRE_W-1:0]   r_pre;
    logic [C_GRD_W-1:0]   r_gcnt;
    logic [2:0]           r_light;
    logic [10:0]          r_code;
    logic                 r_dp_bit;
    logic                 w_slot_tick;
    logic                 w_guard_last;
    logic                 w_blank;
    logic [6:0]           w_seg_dec;

    assign w_slot_tick  = (r_pre == C_PRE_LAST);
    assign w_guard_last = (r_gcnt == C_GRD_LAST);
    assign light        = r_light;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_GUARD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_GUARD: if (w_guard_last) w_state_next = ST_SHOW;
            ST_SHOW:  if (w_slot_tick)  w_state_next = ST_GUARD;
            default:  w_state_next = ST_GUARD;
        endcase
    end

    // ------------------------------------------------------------------
    // Slot prescaler, free running 0..P-1 independent of the FSM, so the
    // slot grid stays fixed relative to reset release.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
        end else if (w_slot_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // Guard counter runs only in GUARD and is parked at zero otherwise,
    // so every guard interval starts counting from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gcnt <= '0;
        end else if ((r_state == ST_GUARD) && !w_guard_last) begin
            r_gcnt <= r_gcnt + 1'b1;
        end else begin
            r_gcnt <= '0;
        end
    end

    // Digit position advances when the slot ends; 3-bit add wraps 7 -> 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_light <= 3'd0;
        end else if ((r_state == ST_SHOW) && w_slot_tick) begin
            r_light <= r_light + 3'd1;
        end
    end

    // Display registers: `num` is only observed here, on the last guard
    // cycle, which keeps `num` off any direct path to the pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code   <= CODE_BLANK;
            r_dp_bit <= 1'b0;
        end else if ((r_state == ST_GUARD) && w_guard_last) begin
            r_code   <= num;
            r_dp_bit <= dp_mask[r_light];
        end
    end

    seg7_decode u_decode (
        .code (r_code),
        .seg  (w_seg_dec)
    );

`ifdef SEG_SCAN_BLINK_EN
    localparam int C_HALF  = CLK_HZ / (2 * BLINK_HZ);
    localparam int C_BLK_W = (C_HALF > 1) ? $clog2(C_HALF) : 1;
    localparam logic [C_BLK_W-1:0] C_BLK_LAST = C_BLK_W'(C_HALF - 1);

    logic [C_BLK_W-1:0] r_blink_cnt;
    logic               r_blink_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt  <= '0;
            r_blink_flag <= 1'b1;
        end else if (r_blink_cnt == C_BLK_LAST) begin
            r_blink_cnt  <= '0;
            r_blink_flag <= ~r_blink_flag;
        end else begin
            r_blink_cnt  <= r_blink_cnt + 1'b1;
        end
    end

    // Mask is applied live so edits take effect within the current slot.
    assign w_blank = ~r_blink_flag & blink_mask[r_light];
`else
    localparam logic [0:0] C_BLINK_TIE = 1'(BLINK_HZ);
    logic w_blink_unused;

    assign w_blink_unused = (^blink_mask) ^ C_BLINK_TIE[0];
    assign w_blank        = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: output logic. Driven only from registers (plus live blink mask);
    // GUARD forces all pins inactive so the anode is off whenever `light`
    // differs from the latched digit.
    // ------------------------------------------------------------------
    always_comb begin
        an  = 8'hFF;
        seg = SEG_OFF;
        dp  = 1'b1;
        if (r_state == ST_SHOW) begin
            seg = w_seg_dec;
            dp  = ~r_dp_bit;
            if (!w_blank) begin
                an = ~(8'h01 << r_light);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_driver
// Description : Scoreboard bench for seg_scan_driver. A reference model
//               derives the expected pins from elapsed time since reset
//               (slot = t/P, phase = t%P, blink half = t/50) and pushes them
//               into a queue; a monitor pops and compares on each negedge.
//               Inputs change only at negedge+2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

    localparam int P    = 10;
    localparam int G    = 2;
    localparam int HALF = 50;

    typedef struct {
        int         t;
        logic [2:0] light;
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  light;
    logic [10:0] num;
    logic [7:0]  blink_mask = 8'h00;
    logic [7:0]  dp_mask = 8'h00;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    logic [10:0] table_q [8];
    exp_t        sb [$];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    // Digit source: combinational lookup on the requested position
    always_comb num = table_q[light];

    seg_scan_driver #(
        .CLK_HZ    (100),
        .SCAN_HZ   (10),
        .GUARD_CYC (G),
        .BLINK_HZ  (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .light      (light),
        .num        (num),
        .blink_mask (blink_mask),
        .dp_mask    (dp_mask),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    function automatic logic [6:0] ref_seg(input int code);
        case (code)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;
            3: return 7'h30;  4: return 7'h19;  5: return 7'h12;
            6: return 7'h02;  7: return 7'h78;  8: return 7'h00;
            9: return 7'h10;  11: return 7'h3F;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic chk(input string name, input int t, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0d got=%h want=%h", name, t, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    int   t = 0;
    int   shown_code = 10;
    logic shown_dp = 1'b0;

    always @(posedge clk) begin : model
        exp_t e;
        int   pos;
        int   phase;
        logic flag;
        logic blank;
        #1;
        if (!rst_n) t = 0;
        else        t = t + 1;
        pos   = (t / P) % 8;
        phase = t % P;
        flag  = ((t / HALF) % 2) == 0;
        if (phase == G) begin
            shown_code = int'(table_q[pos]);
            shown_dp   = dp_mask[pos];
        end
`ifdef SEG_SCAN_BLINK_EN
        blank = !flag && blink_mask[pos];
`else
        blank = 1'b0;
`endif
        e.t     = t;
        e.light = 3'(pos);
        if (phase < G) begin
            e.an  = 8'hFF;
            e.seg = 7'h7F;
            e.dp  = 1'b1;
        end else begin
            e.an  = blank ? 8'hFF : ~(8'h01 << pos);
            e.seg = ref_seg(shown_code);
            e.dp  = !shown_dp;
        end
        sb.push_back(e);
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("light", e.t, 32'(light), 32'(e.light));
            chk("an",    e.t, 32'(an),    32'(e.an));
            chk("seg",   e.t, 32'(seg),   32'(e.seg));
            chk("dp",    e.t, 32'(dp),    32'(e.dp));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) table_q[i] = 11'(i + 1);
        step(3);
        rst_n = 1'b1;

        // counting source over two frames
        step(160);

        // dash / blank / out-of-range codes
        table_q[2] = 11'd11;
        table_q[5] = 11'd10;
        table_q[6] = 11'd300;
        step(160);

        // blink on digit 0
        blink_mask = 8'h01;
        step(200);
        blink_mask = 8'h00;

        // decimal point on digit 2
        dp_mask = 8'h04;
        step(100);

        // asynchronous reset in the middle of digit 5's slot
        begin
            int k;
            k = 0;
            while (light != 3'd5 && k < 200) begin
                step(1);
                k++;
            end
            chk("wait_light5", k, 32'(light), 32'd5);
        end
        step(4);
        rst_n = 1'b0;
        #1;
        chk("async_an",    -1, 32'(an),    32'hFF);
        chk("async_seg",   -1, 32'(seg),   32'h7F);
        chk("async_dp",    -1, 32'(dp),    32'd1);
        chk("async_light", -1, 32'(light), 32'd0);
        step(2);
        rst_n = 1'b1;
        step(120);

        // randomized traffic
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 19) == 0)
                table_q[$urandom_range(0, 7)] = ($urandom_range(0, 3) == 0)
                    ? 11'($urandom_range(0, 2047)) : 11'($urandom_range(0, 11));
            if ($urandom_range(0, 99) == 0) blink_mask = 8'($urandom);
            if ($urandom_range(0, 99) == 0) dp_mask = 8'($urandom);
            step(1);
        end

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
